// File: rtl/median_scan_ctrl.sv
// rtl/median_scan_ctrl.sv - 3x3 binary majority filter sequencer between two single-bit frame RAMs
module median_scan_ctrl #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int THRESH   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] src_x,
    output logic [7:0] src_y,
    input  logic       src_data,
    output logic [7:0] dst_x,
    output logic [7:0] dst_y,
    output logic       dst_data,
    output logic       dst_write
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    localparam logic signed [9:0] W_S    = 10'(IMWIDTH);
    localparam logic signed [9:0] H_S    = 10'(IMHEIGHT);
    localparam logic [7:0]        X_LAST = 8'(IMWIDTH - 1);
    localparam logic [7:0]        Y_LAST = 8'(IMHEIGHT - 1);
    localparam logic [3:0]        THR    = 4'(THRESH);

    state_t state, state_next;

    logic [3:0]        k;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [3:0]        acc;
    logic              oob_prev;
    logic signed [9:0] dx;
    logic signed [9:0] dy;
    logic signed [9:0] nx;
    logic signed [9:0] ny;
    logic              oob;
    logic [3:0]        acc_sum;
    logic              last_x;
    logic              last_y;

    // Ten bits so that x+1 at a 256-wide frame cannot wrap negative.
    always_comb begin
        dx = 10'sd0;
        dy = 10'sd0;
        case (k)
            4'd0, 4'd3, 4'd6: dx = -10'sd1;
            4'd1, 4'd4, 4'd7: dx = 10'sd0;
            default:          dx = 10'sd1;
        endcase
        case (k)
            4'd0, 4'd1, 4'd2: dy = -10'sd1;
            4'd3, 4'd4, 4'd5: dy = 10'sd0;
            default:          dy = 10'sd1;
        endcase
    end

    assign nx      = $signed({2'b00, x}) + dx;
    assign ny      = $signed({2'b00, y}) + dy;
    assign oob     = (nx < 10'sd0) || (nx >= W_S) || (ny < 10'sd0) || (ny >= H_S);
    assign acc_sum = acc + {3'b000, src_data & ~oob_prev};
    assign last_x  = (x == X_LAST);
    assign last_y  = (y == Y_LAST);

    // Out-of-frame neighbours still read the centre so the RAM address stays legal.
    assign src_x = (state == READ && !oob) ? nx[7:0] : x;
    assign src_y = (state == READ && !oob) ? ny[7:0] : y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        dst_write  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                busy = 1'b1;
                if (k == 4'd8) state_next = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                dst_write  = 1'b1;
                state_next = (last_x && last_y) ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= 4'd0;
            x        <= 8'd0;
            y        <= 8'd0;
            acc      <= 4'd0;
            oob_prev <= 1'b0;
            dst_x    <= 8'd0;
            dst_y    <= 8'd0;
            dst_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    k   <= 4'd0;
                    x   <= 8'd0;
                    y   <= 8'd0;
                    acc <= 4'd0;
                end
                READ: begin
                    oob_prev <= oob;
                    k        <= (k == 4'd8) ? 4'd0 : k + 4'd1;
                    if (k != 4'd0) acc <= acc_sum;
                end
                WAIT: begin
                    // Result registers load here so they are stable for the whole WRITE cycle.
                    acc      <= acc_sum;
                    dst_x    <= x;
                    dst_y    <= y;
                    dst_data <= (acc_sum >= THR);
                end
                WRITE: begin
                    acc <= 4'd0;
                    k   <= 4'd0;
                    if (last_x) begin
                        x <= 8'd0;
                        y <= last_y ? 8'd0 : y + 8'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                default: begin
                    k <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_scan_ctrl.sv
// tb/tb_median_scan_ctrl.sv - directed bench for median_scan_ctrl on a 4x3 frame
module tb_median_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] src_x;
    logic [7:0] src_y;
    logic       src_data = 1'b0;
    logic [7:0] dst_x;
    logic [7:0] dst_y;
    logic       dst_data;
    logic       dst_write;

    int checks = 0;
    int errors = 0;

    logic        src_mem [0:11];
    logic [11:0] got = 12'h000;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          order_bad = 0;
    int          wr_base = 0;
    int          mon_idx;
    int          rd_idx;

    median_scan_ctrl #(.IMWIDTH(4), .IMHEIGHT(3), .THRESH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .src_x     (src_x),
        .src_y     (src_y),
        .src_data  (src_data),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .dst_data  (dst_data),
        .dst_write (dst_write)
    );

    always #5 clk = ~clk;

    // Source RAM with one cycle of read latency.
    always @(posedge clk) begin
        rd_idx = int'(src_y) * 4 + int'(src_x);
        src_data <= (rd_idx < 12) ? src_mem[rd_idx] : 1'bx;
    end

    // Destination RAM capture plus raster-order and done-pulse bookkeeping.
    always @(negedge clk) begin
        if (dst_write === 1'b1) begin
            mon_idx = int'(dst_y) * 4 + int'(dst_x);
            if (mon_idx < 12) got[mon_idx] = dst_data;
            if (mon_idx != wr_cnt - wr_base) order_bad = order_bad + 1;
            wr_cnt = wr_cnt + 1;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_src(input logic [11:0] pat);
        for (int i = 0; i < 12; i++) src_mem[i] = pat[i];
    endtask

    task automatic run_frame(input logic [11:0] src, input logic [11:0] exp,
                             input int ra, input int rb, input string tag);
        int n;
        int wb;
        int db;
        int ob;
        load_src(src);
        wb = wr_cnt;
        db = done_cnt;
        ob = order_bad;
        wr_base = wb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && n < 400) begin
            start = (n == ra || n == rb);
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_done_lat"}, n, 32'd133);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_writes"}, wr_cnt - wb, 32'd12);
        check({tag, "_done_pulses"}, done_cnt - db, 32'd1);
        check({tag, "_order"}, order_bad - ob, 32'd0);
        check({tag, "_frame"}, {20'd0, got}, {20'd0, exp});
    endtask

    initial begin
        int n;
        int wb;
        int db;
        reset = 1'b1;
        start = 1'b0;
        load_src(12'hFFF);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dst_write", {31'd0, dst_write}, 32'd0);
        check("rst_dst_data", {31'd0, dst_data}, 32'd0);
        check("rst_addr", {src_x, src_y, dst_x, dst_y}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_frame(12'hFFF, 12'h6F6, -1, -1, "ones");
        run_frame(12'h020, 12'h000, -1, -1, "single");
        run_frame(12'h333, 12'h030, -1, -1, "left_cols");
        run_frame(12'h837, 12'h022, -1, -1, "thresh");
        run_frame(12'hFFF, 12'h6F6, 5, 60, "restart");

        // Abort a pass with reset in cycle 40.
        load_src(12'hFFF);
        wb = wr_cnt;
        db = done_cnt;
        wr_base = wb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("abort_pre_writes", wr_cnt - wb, 32'd3);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_outs", {29'd0, done, dst_write, dst_data}, 32'd0);
        check("abort_addr", {src_x, src_y, dst_x, dst_y}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_no_done", done_cnt - db, 32'd0);
        @(posedge clk); #1;
        run_frame(12'h333, 12'h030, -1, -1, "post_abort");

        // Start held high re-triggers one cycle after DONE.
        load_src(12'hFFF);
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_done_lat", n, 32'd133);
        @(posedge clk); #1;
        check("hold_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("hold_retrigger", {31'd0, busy}, 32'd1);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("hold_abort_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
